serial_pattern_tx: RTL and testbench

//  Bit-serial pattern transmitter. On a Start request it drives a WIDTH-bit

---
 rtl/serial_pattern_tx_pkg.sv | 25 ++
 rtl/tx_shift_counter.sv | 38 +++
 rtl/serial_pattern_tx.sv | 149 ++++++++++++++
 tb/tb_serial_pattern_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared encodings for the serial pattern transmitter and its 1001 detector peer:
// transmitter FSM states, detector state names and the default pattern.
package serial_pattern_tx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Receiving detector's states, kept here so both ends agree on one encoding.
  typedef enum logic [2:0] {
    DET_S0,
    DET_S1,
    DET_S10,
    DET_S100,
    DET_S1001
  } det_state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1001;

  function automatic logic in_run(input logic [1:0] st);
    return (st == ST_SEND) || (st == ST_GAP);
  endfunction

endpackage

// File: rtl/tx_shift_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero.
module tx_shift_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Bit-serial pattern transmitter, MSB first, RepeatCount times with optional gaps.
// Define PATTERN_LOAD_EN to take the pattern from PatternIn at Start instead of PATTERN.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN),
  parameter int               GAP     = 0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [7:0]       RepeatCount,
`ifdef PATTERN_LOAD_EN
  input  logic [WIDTH-1:0] PatternIn,
`endif
  output logic             OutputBit,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       currState
);

  localparam int              IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_load, bit_dec, bit_zero;
  logic [IDX_W-1:0] bit_cnt, idx_next;
  logic             gap_load, gap_dec, gap_zero;
  logic [3:0]       unused_gap_cnt;
  logic [WIDTH-1:0] pat_cur;

`ifdef PATTERN_LOAD_EN
  logic [WIDTH-1:0] pat_q, pat_d;

  // The first bit leaves on the accepting edge, before pat_q has captured it.
  assign pat_cur = (state_q == ST_IDLE) ? PatternIn : pat_q;
  assign pat_d   = (state_q == ST_IDLE && Start && RepeatCount != 8'd0) ? PatternIn : pat_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pat_q <= '0;
    end else begin
      pat_q <= pat_d;
    end
  end
`else
  assign pat_cur = PATTERN;
`endif

  tx_shift_counter #(.W(IDX_W)) u_bit_cnt (
    .clk      (CLK),
    .rst_n    (Reset),
    .load     (bit_load),
    .load_val (IDX_MAX),
    .dec      (bit_dec),
    .count    (bit_cnt),
    .zero     (bit_zero)
  );

  tx_shift_counter #(.W(4)) u_gap_cnt (
    .clk      (CLK),
    .rst_n    (Reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .count    (unused_gap_cnt),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (RepeatCount != 8'd0) begin
            state_d  = ST_SEND;
            rem_d    = RepeatCount;
            bit_load = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (bit_zero) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = ST_DONE;
          end else if (GAP != 0) begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end else begin
            bit_load = 1'b1;
          end
        end else begin
          bit_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_d  = ST_SEND;
          bit_load = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with currState.
    idx_next = bit_load ? IDX_MAX : (bit_cnt - IDX_W'(1));
    out_d    = (state_d == ST_SEND) ? pat_cur[idx_next] : 1'b0;
    busy_d   = in_run(state_d);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      rem_q   <= 8'd0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign OutputBit = out_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign currState = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (GAP=0 and GAP=3) checked every
// cycle against a sequence-level model, plus literal per-run expectations.
module tb_serial_pattern_tx;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] RepeatCount = 8'd0;
`ifdef PATTERN_LOAD_EN
  logic [3:0] PatternIn = 4'b1001;
`endif

  logic       ob [2];
  logic       bz [2];
  logic       dn [2];
  logic [1:0] cs [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;

  always #5 CLK = ~CLK;

  serial_pattern_tx #(.WIDTH(4), .GAP(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .RepeatCount(RepeatCount),
`ifdef PATTERN_LOAD_EN
    .PatternIn(PatternIn),
`endif
    .OutputBit(ob[0]), .Busy(bz[0]), .Done(dn[0]), .currState(cs[0])
  );

  serial_pattern_tx #(.WIDTH(4), .GAP(3)) dut1 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .RepeatCount(RepeatCount),
`ifdef PATTERN_LOAD_EN
    .PatternIn(PatternIn),
`endif
    .OutputBit(ob[1]), .Busy(bz[1]), .Done(dn[1]), .currState(cs[1])
  );

  // Model: each accepted Start expands into the full per-cycle output sequence
  // {state, bit, busy, done}; the instance is idle whenever that list is used up.
  logic [4:0] seq [2][0:127];
  int         len [2] = '{0, 0};
  int         pos [2] = '{0, 0};
  logic [4:0] cur [2] = '{5'd0, 5'd0};
  bit         cur_idle [2] = '{1'b1, 1'b1};

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic build(input int k, input int rc, input logic [3:0] p);
    len[k] = 0;
    pos[k] = 0;
    for (int r = 0; r < rc; r++) begin
      for (int b = 3; b >= 0; b--) begin
        seq[k][len[k]] = {2'd1, p[b], 1'b1, 1'b0};
        len[k]++;
      end
      if (r < rc - 1) begin
        for (int g = 0; g < gap_of(k); g++) begin
          seq[k][len[k]] = {2'd2, 1'b0, 1'b1, 1'b0};
          len[k]++;
        end
      end
    end
    seq[k][len[k]] = {2'd3, 1'b0, 1'b0, 1'b1};
    len[k]++;
  endtask

  initial forever begin
    logic [3:0] p;
    @(posedge CLK or negedge Reset);
`ifdef PATTERN_LOAD_EN
    p = PatternIn;
`else
    p = 4'b1001;
`endif
    for (int k = 0; k < 2; k++) begin
      if (!Reset) begin
        len[k] = 0; pos[k] = 0; cur[k] = 5'd0; cur_idle[k] = 1'b1;
      end else if (cur_idle[k] && Start) begin
        build(k, int'(RepeatCount), p);
        cur[k] = seq[k][pos[k]]; pos[k]++; cur_idle[k] = 1'b0;
      end else if (pos[k] < len[k]) begin
        cur[k] = seq[k][pos[k]]; pos[k]++; cur_idle[k] = 1'b0;
      end else begin
        cur[k] = 5'd0; cur_idle[k] = 1'b1;
      end
    end
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Per-run recorders used by the literal checks.
  logic [31:0] bits [2];
  int          nb [2];
  int          det [2];
  int          dcnt [2];
  int          dat [2];
  logic [3:0]  win [2];

  initial forever begin
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({cs[k], ob[k], bz[k], dn[k]} !== cur[k]) begin
        bad++;
        $display("FAIL cycle dut%0d cyc=%0d: got st=%0d bit=%0b busy=%0b done=%0b, expected st=%0d bit=%0b busy=%0b done=%0b",
                 k, cyc, cs[k], ob[k], bz[k], dn[k], cur[k][4:3], cur[k][2], cur[k][1], cur[k][0]);
      end
      if (bz[k] === 1'b1) begin
        bits[k] = {bits[k][30:0], ob[k]};
        nb[k]++;
      end
      win[k] = {win[k][2:0], ob[k]};
      if (win[k] == 4'b1001) det[k]++;
      if (dn[k] === 1'b1) begin
        dcnt[k]++;
        dat[k] = cyc - t0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    for (int k = 0; k < 2; k++) begin
      bits[k] = '0; nb[k] = 0; det[k] = 0; dcnt[k] = 0; dat[k] = 0;
    end
  endtask

  // Start a run; Start stays high for 'hold' sampling edges; wait for 'need' Done pulses.
  task automatic run(input int rc, input int hold, input int need);
    int waited;
    @(negedge CLK); #1;
    clear_rec();
    t0 = cyc;
    RepeatCount = 8'(rc);
    Start = 1'b1;
    repeat (hold) @(negedge CLK);
    #1 Start = 1'b0;
    waited = 0;
    while ((dcnt[0] < need || dcnt[1] < need) && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    chk("run_timeout", 32'(waited < 200), 32'd1);
    repeat (3) @(negedge CLK);
    $display("run rc=%0d: dut0 bits=%0d done@%0d det=%0d | dut1 bits=%0d done@%0d det=%0d",
             rc, nb[0], dat[0], det[0], nb[1], dat[1], det[1]);
  endtask

  initial begin
    clear_rec();
    win[0] = 4'd0; win[1] = 4'd0;
    repeat (2) @(negedge CLK);
    chk("reset_state", {30'd0, cs[0]}, 32'd0);
    chk("reset_outs", {29'd0, ob[0], bz[1], dn[1]}, 32'd0);
    #2 Reset = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset asserted mid-SEND aborts at once and never produces Done.
    @(negedge CLK); #1;
    clear_rec();
    RepeatCount = 8'd5; Start = 1'b1;
    @(negedge CLK); #1 Start = 1'b0;
    repeat (6) @(posedge CLK);
    #3 Reset = 1'b0;
    #1;
    chk("abort_outs0", {29'd0, ob[0], bz[0], dn[0]}, 32'd0);
    chk("abort_state0", {30'd0, cs[0]}, 32'd0);
    chk("abort_busy1", {31'd0, bz[1]}, 32'd0);
    repeat (2) @(negedge CLK);
    #2 Reset = 1'b1;
    repeat (8) @(negedge CLK);
    chk("abort_no_done", 32'(dcnt[0] + dcnt[1]), 32'd0);
    chk("abort_idle", {28'd0, cs[0], cs[1]}, 32'd0);
    $display("reset abort checked");

    run(1, 1, 1);
    chk("rc1_bits", bits[0], 32'b1001);
    chk("rc1_nbits", 32'(nb[0]), 32'd4);
    chk("rc1_done_at", 32'(dat[0]), 32'd5);
    chk("rc1_det", 32'(det[0]), 32'd1);
    chk("rc1_gap_dut_bits", bits[1], 32'b1001);

    run(3, 1, 1);
    chk("rc3_bits", bits[0], 32'b100110011001);
    chk("rc3_busy", 32'(nb[0]), 32'd12);
    chk("rc3_det", 32'(det[0]), 32'd3);
    chk("rc3_done_cnt", 32'(dcnt[0]), 32'd1);
    chk("rc3_gap_bits", bits[1], 32'b100100010010001001);

    run(2, 1, 1);
    chk("gap3_bits", bits[1], 32'b10010001001);
    chk("gap3_nbits", 32'(nb[1]), 32'd11);
    chk("gap3_done_at", 32'(dat[1]), 32'd12);
    chk("gap3_det", 32'(det[1]), 32'd2);
    chk("rc2_done_at", 32'(dat[0]), 32'd9);

    run(0, 1, 1);
    chk("rc0_done_at", 32'(dat[0]), 32'd1);
    chk("rc0_busy", 32'(nb[0] + nb[1]), 32'd0);

`ifdef PATTERN_LOAD_EN
    PatternIn = 4'b0110;
`endif
    // Start held across seven sampling edges: ignored mid-run, restarts from IDLE.
    run(1, 7, 2);
`ifdef PATTERN_LOAD_EN
    chk("hold_bits", bits[0], 32'b01100110);
`else
    chk("hold_bits", bits[0], 32'b10011001);
`endif
    chk("hold_nbits", 32'(nb[0]), 32'd8);
    chk("hold_done_cnt", 32'(dcnt[0]), 32'd2);
    chk("hold_second_done", 32'(dat[0]), 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
